// File: rtl/lbc_pkg.sv
// Shared types and helpers for the LBC initiator-side transmit path.
package lbc_pkg;

  localparam int LBC_DW = 32;

  typedef enum logic {
    LBC_TX_IDLE     = 1'b0,
    LBC_TX_WAIT_ACK = 1'b1
  } lbc_tx_state_e;

  // One extra wrap bit beyond the address lets full and empty be told apart.
  function automatic int lbc_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lbc_tx_fifo.sv
// Register FIFO holding words queued for the crossing; head is the word on the wire.
module lbc_tx_fifo
  import lbc_pkg::*;
#(
  parameter int DW    = LBC_DW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          multi,
  output logic [DW-1:0] head
);

  localparam int PW = lbc_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign multi   = (count > PW'(1));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/lbc_async_tx.sv
// Initiator end of the LBC valid/ack crossing: queues words and launches them one at a time.
// state           | meaning
// LBC_TX_IDLE     | nothing outstanding; launches as soon as the FIFO has a word
// LBC_TX_WAIT_ACK | head word on DATAO, waiting for ACKI to complete it
module lbc_async_tx
  import lbc_pkg::*;
#(
  parameter int DW          = LBC_DW,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic          CLOCKII,
  input  logic          RESET_D1_IR_N,
  input  logic          LBC_SYNC_MODE,
  input  logic          PUSH,
  input  logic [DW-1:0] PUSH_DATA,
  output logic          FULL,
  output logic          EMPTY,
  output logic          VALIDO,
  input  logic          ACKI,
  output logic [DW-1:0] DATAO,
  output logic          BUSY,
  output logic          TIMEOUT_ERR,
  output logic          SPUR_ACK_ERR,
  input  logic          ERR_CLR
);

  localparam int            TW      = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT);

  lbc_tx_state_e state;
  lbc_tx_state_e state_nxt;
  logic          pop;
  logic          launch;
  logic          fifo_multi;
  logic          tog;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_cnt_nxt;
  logic          tmo_set;
  logic          spur_set;

  lbc_tx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLOCKII),
    .rst_n     (RESET_D1_IR_N),
    .push      (PUSH),
    .push_data (PUSH_DATA),
    .pop       (pop),
    .full      (FULL),
    .empty     (EMPTY),
    .multi     (fifo_multi),
    .head      (DATAO)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    launch    = 1'b0;
    case (state)
      LBC_TX_IDLE: begin
        if (!EMPTY) begin
          launch    = 1'b1;
          state_nxt = LBC_TX_WAIT_ACK;
        end
      end
      LBC_TX_WAIT_ACK: begin
        if (ACKI) begin
          pop = 1'b1;
          // A same-edge push always lands, so it keeps the FIFO non-empty after the pop.
          if (fifo_multi || PUSH) launch = 1'b1;
          else                    state_nxt = LBC_TX_IDLE;
        end
      end
      default: state_nxt = LBC_TX_IDLE;
    endcase
  end

  always_comb begin
    tmo_cnt_nxt = tmo_cnt;
    tmo_set     = 1'b0;
    if (launch || pop) begin
      tmo_cnt_nxt = '0;
    end else if (state == LBC_TX_WAIT_ACK) begin
      if (tmo_cnt != TMO_MAX) tmo_cnt_nxt = tmo_cnt + 1'b1;
      tmo_set = (ACK_TIMEOUT != 0) && (tmo_cnt_nxt == TMO_MAX);
    end
  end

  assign spur_set = (state == LBC_TX_IDLE) && ACKI;
  assign BUSY     = (state == LBC_TX_WAIT_ACK);
  assign VALIDO   = LBC_SYNC_MODE ? BUSY : tog;

  always_ff @(posedge CLOCKII or negedge RESET_D1_IR_N) begin
    if (!RESET_D1_IR_N) begin
      state        <= LBC_TX_IDLE;
      tog          <= 1'b0;
      tmo_cnt      <= '0;
      TIMEOUT_ERR  <= 1'b0;
      SPUR_ACK_ERR <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      // Parity only advances in toggle mode so the far end stays in step across mode changes.
      if (launch && !LBC_SYNC_MODE) tog <= ~tog;
      TIMEOUT_ERR  <= tmo_set  | (TIMEOUT_ERR  & ~ERR_CLR);
      SPUR_ACK_ERR <= spur_set | (SPUR_ACK_ERR & ~ERR_CLR);
    end
  end

endmodule

// File: tb/tb_lbc_async_tx.sv
// Bench for lbc_async_tx: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_lbc_async_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic          CLOCKII = 1'b0;
  logic          RESET_D1_IR_N;
  logic          LBC_SYNC_MODE;
  logic          PUSH;
  logic [DW-1:0] PUSH_DATA;
  logic          FULL;
  logic          EMPTY;
  logic          VALIDO;
  logic          ACKI;
  logic [DW-1:0] DATAO;
  logic          BUSY;
  logic          TIMEOUT_ERR;
  logic          SPUR_ACK_ERR;
  logic          ERR_CLR;

  lbc_async_tx #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .CLOCKII       (CLOCKII),
    .RESET_D1_IR_N (RESET_D1_IR_N),
    .LBC_SYNC_MODE (LBC_SYNC_MODE),
    .PUSH          (PUSH),
    .PUSH_DATA     (PUSH_DATA),
    .FULL          (FULL),
    .EMPTY         (EMPTY),
    .VALIDO        (VALIDO),
    .ACKI          (ACKI),
    .DATAO         (DATAO),
    .BUSY          (BUSY),
    .TIMEOUT_ERR   (TIMEOUT_ERR),
    .SPUR_ACK_ERR  (SPUR_ACK_ERR),
    .ERR_CLR       (ERR_CLR)
  );

  always #5 CLOCKII = ~CLOCKII;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of pending words plus protocol-level flags.
  logic [DW-1:0] m_q[$];
  bit            m_busy;
  bit            m_tog;
  bit            m_tmo;
  bit            m_spur;
  int            m_cnt;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0;
    m_tog  = 0;
    m_tmo  = 0;
    m_spur = 0;
    m_cnt  = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic p, input logic [DW-1:0] d, input logic a, input logic c);
    int pre_size = m_q.size();
    bit launch   = 0;
    bit tset     = 0;
    bit sset     = !m_busy && a;
    if (m_busy && a) void'(m_q.pop_front());
    if (p && m_q.size() < DEPTH) m_q.push_back(d);
    if (!m_busy) begin
      if (pre_size > 0) begin
        launch = 1;
        m_busy = 1;
      end
    end else if (a) begin
      if (m_q.size() > 0) launch = 1;
      else                m_busy = 0;
      m_cnt = 0;
    end else begin
      if (m_cnt < TMO) m_cnt++;
      if (TMO != 0 && m_cnt == TMO) tset = 1;
    end
    if (launch) begin
      m_cnt = 0;
      if (!LBC_SYNC_MODE) m_tog = !m_tog;
    end
    m_tmo  = tset || (m_tmo && !c);
    m_spur = sset || (m_spur && !c);
  endtask

  task automatic cmp_model(input string tag);
    chk1({tag, ".valido"}, VALIDO, LBC_SYNC_MODE ? m_busy : m_tog);
    chk1({tag, ".busy"},   BUSY,   m_busy);
    chk1({tag, ".empty"},  EMPTY,  m_q.size() == 0);
    chk1({tag, ".full"},   FULL,   m_q.size() == DEPTH);
    chk1({tag, ".tmo"},    TIMEOUT_ERR,  m_tmo);
    chk1({tag, ".spur"},   SPUR_ACK_ERR, m_spur);
    if (m_q.size() > 0) chk32({tag, ".data"}, DATAO, m_q[0]);
  endtask

  // Drive one cycle of inputs, step the model, and return #1 after the edge.
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic a, input logic c);
    PUSH      = p;
    PUSH_DATA = d;
    ACKI      = a;
    ERR_CLR   = c;
    model_step(p, d, a, c);
    @(posedge CLOCKII);
    #1;
    PUSH    = 1'b0;
    ACKI    = 1'b0;
    ERR_CLR = 1'b0;
  endtask

  // Asserts reset between edges and checks reset values before any edge arrives.
  task automatic do_reset(input logic mode);
    RESET_D1_IR_N = 1'b0;
    PUSH          = 1'b0;
    PUSH_DATA     = '0;
    ACKI          = 1'b0;
    ERR_CLR       = 1'b0;
    LBC_SYNC_MODE = mode;
    model_reset();
    #2;
    chk1("rst.valido", VALIDO, 1'b0);
    chk1("rst.busy",   BUSY,   1'b0);
    chk1("rst.empty",  EMPTY,  1'b1);
    chk1("rst.full",   FULL,   1'b0);
    chk32("rst.data",  DATAO,  '0);
    chk1("rst.tmo",    TIMEOUT_ERR,  1'b0);
    chk1("rst.spur",   SPUR_ACK_ERR, 1'b0);
    @(posedge CLOCKII);
    #1;
    RESET_D1_IR_N = 1'b1;
  endtask

  typedef struct {
    logic          rst;
    logic          push;
    logic [DW-1:0] pd;
    logic          ack;
    logic          v;
    logic          b;
    logic          e;
    logic          f;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] z[5];
    bit            sm;

    // rst push data ack | valido busy empty full data
    tbl[0]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000};
    tbl[6]  = '{1'b0, 1'b1, 32'h1000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1000_0000};
    tbl[7]  = '{1'b0, 1'b1, 32'h1000_0002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1000_0000};
    tbl[8]  = '{1'b0, 1'b1, 32'h1000_0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000};
    tbl[9]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0001};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1000_0002};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0003};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

    RESET_D1_IR_N = 1'b1;
    #3;
    do_reset(1'b0);

    // Async single word, then a burst that overfills the FIFO.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset(1'b0);
      cyc(tbl[i].push, tbl[i].pd, tbl[i].ack, 1'b0);
      chk1($sformatf("vec%0d.valido", i), VALIDO, tbl[i].v);
      chk1($sformatf("vec%0d.busy", i),   BUSY,   tbl[i].b);
      chk1($sformatf("vec%0d.empty", i),  EMPTY,  tbl[i].e);
      chk1($sformatf("vec%0d.full", i),   FULL,   tbl[i].f);
      if (!tbl[i].e) chk32($sformatf("vec%0d.data", i), DATAO, tbl[i].d);
    end

    // Sync mode: level valid, one completion per cycle under a held ack.
    do_reset(1'b1);
    cyc(1'b1, 32'h5555_0000, 1'b0, 1'b0);
    chk1("sync.idle_valido", VALIDO, 1'b0);
    cyc(1'b1, 32'h5555_0001, 1'b0, 1'b0);
    chk1("sync.launch_valido", VALIDO, 1'b1);
    chk32("sync.launch_data", DATAO, 32'h5555_0000);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk1("sync.second_valido", VALIDO, 1'b1);
    chk32("sync.second_data", DATAO, 32'h5555_0001);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk1("sync.done_valido", VALIDO, 1'b0);
    chk1("sync.done_empty", EMPTY, 1'b1);
    cmp_model("sync");

    // Timeout at exactly TMO cycles of waiting; late ack still completes.
    do_reset(1'b0);
    cyc(1'b1, 32'h0BAD_0001, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (TMO - 1) cyc(1'b0, '0, 1'b0, 1'b0);
    chk1("tmo.before", TIMEOUT_ERR, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk1("tmo.set", TIMEOUT_ERR, 1'b1);
    chk1("tmo.valido_held", VALIDO, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    chk1("tmo.no_retoggle", VALIDO, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk1("tmo.late_ack_busy", BUSY, 1'b0);
    chk1("tmo.sticky", TIMEOUT_ERR, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk1("tmo.cleared", TIMEOUT_ERR, 1'b0);

    // Spurious ack, clear-vs-set priority, and push+pop while full.
    do_reset(1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk1("spur.set", SPUR_ACK_ERR, 1'b1);
    chk1("spur.no_launch", BUSY, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk1("spur.clr", SPUR_ACK_ERR, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk1("spur.set_wins", SPUR_ACK_ERR, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) z[i] = 32'hC0DE_0000 + i;
    for (int i = 0; i < 4; i++) cyc(1'b1, z[i], 1'b0, 1'b0);
    chk1("full.reached", FULL, 1'b1);
    cyc(1'b1, z[4], 1'b1, 1'b0);
    chk1("full.push_pop_full", FULL, 1'b1);
    chk32("full.push_pop_head", DATAO, z[1]);
    for (int i = 2; i < 5; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk32($sformatf("full.drain%0d", i), DATAO, z[i]);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk1("full.drained", EMPTY, 1'b1);
    cmp_model("spur");

    // Reset while a word is outstanding.
    do_reset(1'b0);
    cyc(1'b1, 32'h7777_0001, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk1("midrst.pre_busy", BUSY, 1'b1);
    do_reset(1'b0);

    // Random traffic with occasional mode changes while idle and empty.
    for (int seg = 0; seg < 20; seg++) begin
      for (int k = 0; k < 8 && (m_busy || m_q.size() > 0); k++)
        cyc(1'b0, '0, logic'(m_busy), 1'b0);
      sm = bit'($urandom_range(0, 1));
      LBC_SYNC_MODE = sm;
      for (int c = 0; c < 100; c++) begin
        logic p, a, cl;
        p  = logic'($urandom_range(0, 1));
        a  = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
        cl = ($urandom_range(0, 15) == 0);
        cyc(p, $urandom, a, cl);
        cmp_model($sformatf("rnd%0d_%0d", seg, c));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
